// File: rtl/axis_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// axis_pack_pkg
// Shared configuration and types for the AXI-Stream word packer.
//   WORD_W          : width of one input word.
//   WORDS_PER_BEAT  : words packed into one output beat (power of two, >= 2).
//   BEATS_PER_FRAME : beats per tlast-delimited frame (power of two, >= 1).
//   CNT_W           : width of the completed-frame counter.
//   beat_t          : one output beat {data, keep, last}.
// -----------------------------------------------------------------------------
package axis_pack_pkg;

  localparam int WORD_W          = 16;
  localparam int WORDS_PER_BEAT  = 4;
  localparam int BEATS_PER_FRAME = 8;
  localparam int CNT_W           = 32;

  localparam int BEAT_W     = WORD_W * WORDS_PER_BEAT;
  localparam int LANE_IDX_W = $clog2(WORDS_PER_BEAT);
  // A one-beat frame still needs a 1-bit index so the counter logic stays uniform.
  localparam int BEAT_IDX_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;

  typedef struct packed {
    logic [BEAT_W-1:0]         data;
    logic [WORDS_PER_BEAT-1:0] keep;
    logic                      last;
  } beat_t;

endpackage

// File: rtl/axis_word_packer_if.sv
// -----------------------------------------------------------------------------
// axis_word_packer_if
// Bundles the scalar word input stream and the packed AXI-Stream output.
//   s_valid/s_ready/s_data/s_last : word stream into the packer.
//   m_valid/m_ready/m_data/m_keep/m_last : packed beats out of the packer.
// Modports:
//   slave  : the packer's view (consumes words, produces beats).
//   master : the environment's view (produces words, consumes beats).
// -----------------------------------------------------------------------------
interface axis_word_packer_if;
  import axis_pack_pkg::*;

  logic                      s_valid;
  logic                      s_ready;
  logic [WORD_W-1:0]         s_data;
  logic                      s_last;

  logic                      m_valid;
  logic                      m_ready;
  logic [BEAT_W-1:0]         m_data;
  logic [WORDS_PER_BEAT-1:0] m_keep;
  logic                      m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/axis_word_packer_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single-entry pipeline register for one packed beat.
//   aclk, areset      : clock, asynchronous active-high reset.
//   load_valid_i      : a new beat is offered this cycle.
//   load_beat_i       : the beat to store.
//   out_ready_i       : downstream accepts the held beat.
//   valid_o, beat_o   : held beat and its valid flag.
//   ready_o           : register can take a new beat (empty or draining).
// -----------------------------------------------------------------------------
module axis_out_reg
  import axis_pack_pkg::*;
(
  input  logic  aclk,
  input  logic  areset,
  input  logic  load_valid_i,
  input  beat_t load_beat_i,
  input  logic  out_ready_i,
  output logic  valid_o,
  output beat_t beat_o,
  output logic  ready_o
);

  logic  valid_q, valid_d;
  beat_t beat_q, beat_d;

  // Empty or draining this cycle: a new beat may replace the current one.
  assign ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (ready_o) begin
      valid_d = load_valid_i;
      // Data is left untouched when nothing loads, so it only changes on a load.
      if (load_valid_i) begin
        beat_d = load_beat_i;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign valid_o = valid_q;
  assign beat_o  = beat_q;

endmodule

// File: rtl/axis_word_packer.sv
// -----------------------------------------------------------------------------
// axis_word_packer
// Packs WORDS_PER_BEAT scalar words into each AXI-Stream beat and frames the
// beats with tlast every BEATS_PER_FRAME beats, or early on s_last (which
// flushes a partial beat with a low-order contiguous keep mask).
//   aclk, areset : clock, asynchronous active-high reset.
//   bus          : word input stream and packed beat output (slave modport).
//   frame_count  : frames fully transferred (tlast beat accepted), wraps.
// -----------------------------------------------------------------------------
module axis_word_packer
  import axis_pack_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset,
  axis_word_packer_if.slave    bus,
  output logic [CNT_W-1:0]     frame_count
);

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(WORDS_PER_BEAT - 1);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_FRAME - 1);

  logic [LANE_IDX_W-1:0]     widx_q, widx_d;
  logic [BEAT_IDX_W-1:0]     bidx_q, bidx_d;
  logic [BEAT_W-1:0]         acc_data_q, acc_data_d;
  logic [WORDS_PER_BEAT-1:0] acc_keep_q, acc_keep_d;
  logic [CNT_W-1:0]          frame_count_q, frame_count_d;

  logic                      out_ready;
  logic                      out_valid;
  beat_t                     out_beat;
  beat_t                     load_beat;
  logic                      accept;
  logic                      complete;
  logic                      beat_last;
  logic [WORDS_PER_BEAT-1:0] lane_sel;
  logic [BEAT_W-1:0]         merged_data;
  logic [WORDS_PER_BEAT-1:0] merged_keep;

  assign bus.s_ready = out_ready;
  assign accept      = bus.s_valid && out_ready;
  assign complete    = accept && ((widx_q == LAST_LANE) || bus.s_last);
  assign beat_last   = (bidx_q == LAST_BEAT) || bus.s_last;

  // Accumulator with the incoming word dropped into lane widx; this is both
  // the next accumulator value and, on completion, the beat to emit.
  for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_lane
    assign lane_sel[gi] = (widx_q == LANE_IDX_W'(gi));
    assign merged_data[gi*WORD_W +: WORD_W] =
      lane_sel[gi] ? bus.s_data : acc_data_q[gi*WORD_W +: WORD_W];
  end
  assign merged_keep = acc_keep_q | lane_sel;

  always_comb begin
    load_beat      = '0;
    load_beat.data = merged_data;
    load_beat.keep = merged_keep;
    load_beat.last = beat_last;
  end

  always_comb begin
    widx_d        = widx_q;
    bidx_d        = bidx_q;
    acc_data_d    = acc_data_q;
    acc_keep_d    = acc_keep_q;
    frame_count_d = frame_count_q;

    if (accept) begin
      if (complete) begin
        acc_data_d = '0;
        acc_keep_d = '0;
        widx_d     = '0;
        bidx_d     = beat_last ? '0 : bidx_q + BEAT_IDX_W'(1);
      end else begin
        acc_data_d = merged_data;
        acc_keep_d = merged_keep;
        widx_d     = widx_q + LANE_IDX_W'(1);
      end
    end

    if (out_valid && bus.m_ready && out_beat.last) begin
      frame_count_d = frame_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      widx_q        <= '0;
      bidx_q        <= '0;
      acc_data_q    <= '0;
      acc_keep_q    <= '0;
      frame_count_q <= '0;
    end else begin
      widx_q        <= widx_d;
      bidx_q        <= bidx_d;
      acc_data_q    <= acc_data_d;
      acc_keep_q    <= acc_keep_d;
      frame_count_q <= frame_count_d;
    end
  end

  axis_out_reg u_out_reg (
    .aclk         (aclk),
    .areset       (areset),
    .load_valid_i (complete),
    .load_beat_i  (load_beat),
    .out_ready_i  (bus.m_ready),
    .valid_o      (out_valid),
    .beat_o       (out_beat),
    .ready_o      (out_ready)
  );

  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_beat.data;
  assign bus.m_keep  = out_beat.keep;
  assign bus.m_last  = out_beat.last;
  assign frame_count = frame_count_q;

endmodule
